acc_cpu_core: RTL and testbench
===============================

# acc_cpu_core

Parametrised accumulator CPU core, the next generation of the team's 4-bit tiny accumulator CPU. It widens the datapath to DATA_W bits and adds a small register file, a full flag set (Z/N/C/V), multi-cycle shifts and an optional multiplier. Instructions arrive through a valid/ready handshake from the TinyTapeout top-level wrapper. The wrapper maps ui_in/uio_in onto the instruction port and uo_out onto the accumulator and flags.

## Interface
- DATA_W, 8: accumulator, register and operand width; power of two, ≥4.
- NREGS, 4: register file depth; power of two, ≤2^DATA_W.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; when low, no instruction is accepted and state holds
- instr_valid  in  1  instruction present
- instr_opcode  in  4  opcode
- instr_operand  in  DATA_W  immediate or register index (low log2(NREGS) bits)
- instr_ready  out  1  core accepts this cycle; accept = valid & ready
- acc_out  out  DATA_W  accumulator
- flags_out  out  4  {V,C,N,Z}
- result_valid  out  1  one-cycle pulse; acc_out and flags_out are final
- busy  out  1  multi-cycle op in progress
- illegal  out  1  one-cycle pulse; reserved or disabled opcode accepted

## Operation
- Opcodes: 0 NOP, 1 LDI, 2 ADD imm, 3 SUB imm, 4 AND, 5 OR, 6 XOR, 7 STR reg[idx]=acc, 8 LDR acc=reg[idx], 9 ADDR acc+=reg[idx], A SHL by amt, B SHR (logical) by amt, C MUL (acc*imm, low DATA_W bits), D CLR, E ADC (acc+imm+C), F reserved.
- amt = operand[log2(DATA_W)-1:0]. amt=0 completes as a single-cycle op: acc and C are unchanged; Z and N are updated.
- Flags:
  - ADD/ADC/ADDR: C = carry-out, V = signed overflow.
  - SUB: C = borrow, V = signed overflow.
  - AND/OR/XOR/CLR: C=0, V=0.
  - SHL/SHR: C = last bit shifted out; V unchanged.
  - MUL: C = 1 if any discarded high bit is nonzero; V=0.
  - LDI/LDR: C and V unchanged.
  - Z and N are recomputed on every acc-writing op.
  - NOP and STR leave all flags unchanged.
- FSM states:
  - IDLE: instr_ready=ena.
  - SHIFT: ready=0, busy=1, down-counter = amt; one bit per cycle.
  - MUL: ready=0, busy=1, shift-add over DATA_W cycles.
- Transitions:
  - IDLE→SHIFT on accepted SHL/SHR with amt≠0.
  - IDLE→MUL on accepted MUL.
  - Back to IDLE on the last iteration.
- While SHIFT or MUL is active, ena low freezes the counter and datapath. Work resumes when ena returns high.
- Opcode F, or C with the multiplier disabled: no state change except the illegal pulse; result_valid still pulses.
- Reset values: acc 0, all registers 0, flags 0, state IDLE, busy 0, result_valid 0, illegal 0. instr_ready = ena after reset.
- Reset asserted mid-operation aborts the op immediately; no result_valid is issued.

## Timing
- Single-cycle op accepted at edge k: acc, flags and registers update at k; result_valid is high in the cycle after k.
- SHL/SHR with amt≠0: shifts occur at edges k+1..k+amt; result_valid is high after edge k+amt; instr_ready is low for amt cycles.
- MUL: result_valid is high after edge k+DATA_W; instr_ready is low for DATA_W cycles.
- Back-to-back single-cycle ops sustain 1 per cycle.
- ADDR/LDR reading a register written by the immediately preceding STR must return the new value (write-then-read forwarding).
- All outputs are registered; no combinational path from inputs to outputs except ena → instr_ready.

## Configuration
- CPU_MUL_EN defined: opcode C executes the shift-add multiplier (MUL state).
- CPU_MUL_EN undefined: the MUL state and datapath are removed; opcode C is treated as illegal (illegal pulse, no state change, 1-cycle latency).

## Structure
- Package acc_cpu_pkg holds:
  - opcode localparams
  - FSM state typedef (IDLE/SHIFT/MUL)
  - flag bit index constants
- Sub-module acc_cpu_alu: combinational single-cycle ALU. Inputs: acc, operand, reg data, C. Outputs: result and next flags.
- The core owns the FSM, counters, register file and handshake.

## Test plan
Tests use DATA_W=8 and NREGS=4.
- Reset, then idle with ena=1 → acc_out=0x00, flags=0, instr_ready=1, busy=0.
- LDI 0xF0, ADD 0x20 → acc=0x10, C=1, V=0, Z=0; result_valid pulses one cycle after each accept, back-to-back.
- LDI 0x7F, ADD 0x01 → acc=0x80, N=1, V=1, C=0. Then LDI 0x05, SUB 0x05 → acc=0x00, Z=1, C=0.
- LDI 0x3C, STR r2, CLR, ADDR r2 (ADDR issued directly after STR) → acc=0x3C; register r2 reads 0x3C.
- LDI 0x21, SHL 3 → instr_ready low for 3 cycles; result_valid 4 cycles after accept; acc=0x08, C=1. Same setup with SHR 0 → acc=0x21 after 1 cycle.
- With CPU_MUL_EN:
  - LDI 0x12, MUL 0x0E → acc=0xFC, C=0, latency 9 cycles.
  - LDI 0x20, MUL 0x10 → acc=0x00, Z=1, C=1.
  - rst_n pulsed mid-MUL → acc=0, no result_valid.
- Without CPU_MUL_EN: MUL → illegal pulse, acc unchanged.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcodes, FSM state type and flag layout shared by the accumulator CPU
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_LDR  = 4'h8;
    localparam logic [3:0] OP_ADDR = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_CLR  = 4'hD;
    localparam logic [3:0] OP_ADC  = 4'hE;
    localparam logic [3:0] OP_RSV  = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    function automatic logic [3:0] mk_flags(input logic v, input logic c, input logic n, input logic z);
        logic [3:0] f;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// acc_cpu_if: instruction handshake and result bus between the wrapper (master) and the core (slave)
interface acc_cpu_if #(parameter int DATA_W = 8);
    logic              ena;
    logic              instr_valid;
    logic [3:0]        instr_opcode;
    logic [DATA_W-1:0] instr_operand;
    logic              instr_ready;
    logic [DATA_W-1:0] acc_out;
    logic [3:0]        flags_out;
    logic              result_valid;
    logic              busy;
    logic              illegal;

    modport master (
        output ena, instr_valid, instr_opcode, instr_operand,
        input  instr_ready, acc_out, flags_out, result_valid, busy, illegal
    );

    modport slave (
        input  ena, instr_valid, instr_opcode, instr_operand,
        output instr_ready, acc_out, flags_out, result_valid, busy, illegal
    );
endinterface

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational single-cycle ALU producing the next accumulator and flags
module acc_cpu_alu import acc_cpu_pkg::*; #(parameter int DATA_W = 8) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_operand,
    input  logic [DATA_W-1:0] i_reg,
    input  logic [3:0]        i_flags,
    output logic [DATA_W-1:0] o_res,
    output logic [3:0]        o_flags
);
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic              w_c;
    logic              w_v;
    logic              w_zn;

    assign w_b    = i_op == OP_ADDR ? i_reg : i_operand;
    assign w_sum  = {1'b0, i_acc} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_op == OP_ADC && i_flags[FLAG_C]};
    assign w_diff = {1'b0, i_acc} - {1'b0, w_b};

    // Opcode decode; shifts by zero and NOP/STR/illegal keep acc, Z/N follow any acc-writing op
    always_comb begin
        o_res = i_acc;
        w_c   = i_flags[FLAG_C];
        w_v   = i_flags[FLAG_V];
        w_zn  = 1'b1;
        case (i_op)
            OP_LDI: o_res = i_operand;
            OP_ADD, OP_ADC, OP_ADDR: begin
                o_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (i_acc[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_acc[DATA_W-1]);
            end
            OP_SUB: begin
                o_res = w_diff[DATA_W-1:0];
                w_c   = w_diff[DATA_W];
                w_v   = (i_acc[DATA_W-1] != w_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_acc[DATA_W-1]);
            end
            OP_AND: begin
                o_res = i_acc & i_operand;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_OR: begin
                o_res = i_acc | i_operand;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_XOR: begin
                o_res = i_acc ^ i_operand;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_LDR: o_res = i_reg;
            OP_CLR: begin
                o_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_SHL, OP_SHR: ;
            default: w_zn = 1'b0;
        endcase
        o_flags = mk_flags(w_v, w_c, w_zn ? o_res[DATA_W-1] : i_flags[FLAG_N],
                           w_zn ? o_res == '0 : i_flags[FLAG_Z]);
    end
endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: accumulator CPU core with register file, multi-cycle shifts and optional multiplier (CPU_MUL_EN)
module acc_cpu_core import acc_cpu_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input logic         clk,
    input logic         rst_n,
    acc_cpu_if.slave    bus
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int IX_W  = NREGS > 1 ? $clog2(NREGS) : 1;
    localparam int CNT_W = SH_W + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_acc;
    logic [3:0]        r_flags;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [CNT_W-1:0]  r_cnt;
    logic              r_left;
    logic              r_result_valid;
    logic              r_illegal;
    logic              w_ready;
    logic              w_busy;
    logic              w_accept;
    logic              w_is_shift;
    logic              w_is_mul;
    logic              w_illegal_op;
    logic              w_last;
    logic [SH_W-1:0]   w_amt;
    logic [IX_W-1:0]   w_idx;
    logic [DATA_W-1:0] w_reg_rd;
    logic [DATA_W-1:0] w_alu_res;
    logic [3:0]        w_alu_flags;
    logic [DATA_W-1:0] w_sh_res;
    logic              w_sh_c;

    assign w_amt      = bus.instr_operand[SH_W-1:0];
    assign w_idx      = bus.instr_operand[IX_W-1:0];
    assign w_reg_rd   = r_regs[w_idx];
    assign w_accept   = bus.instr_valid && w_ready;
    assign w_is_shift = (bus.instr_opcode == OP_SHL || bus.instr_opcode == OP_SHR) && w_amt != '0;
    assign w_last     = r_cnt == CNT_W'(1);
    assign w_sh_res   = r_left ? {r_acc[DATA_W-2:0], 1'b0} : {1'b0, r_acc[DATA_W-1:1]};
    assign w_sh_c     = r_left ? r_acc[DATA_W-1] : r_acc[0];
`ifdef CPU_MUL_EN
    assign w_is_mul     = bus.instr_opcode == OP_MUL;
    assign w_illegal_op = bus.instr_opcode == OP_RSV;
`else
    assign w_is_mul     = 1'b0;
    assign w_illegal_op = bus.instr_opcode == OP_RSV || bus.instr_opcode == OP_MUL;
`endif

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op      (bus.instr_opcode),
        .i_acc     (r_acc),
        .i_operand (bus.instr_operand),
        .i_reg     (w_reg_rd),
        .i_flags   (r_flags),
        .o_res     (w_alu_res),
        .o_flags   (w_alu_flags)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;

    // Next state: enter SHIFT/MUL on accept, leave on the last enabled iteration
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && w_is_shift) w_state_nxt = SHIFT;
        if (w_accept && w_is_mul) w_state_nxt = MUL;
        if (r_state != IDLE && bus.ena && w_last) w_state_nxt = IDLE;
    end

    // FSM outputs: ready only while idle and enabled
    always_comb begin
        w_ready = bus.ena && r_state == IDLE;
        w_busy  = r_state != IDLE;
    end

`ifdef CPU_MUL_EN
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mpl;
    logic [2*DATA_W-1:0] r_prod;
    logic [2*DATA_W-1:0] w_prod_nxt;

    assign w_prod_nxt = r_prod + (r_mpl[0] ? r_mcand : '0);

    // Shift-add multiplier: one multiplier bit per enabled cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_mcand <= '0;
            r_mpl   <= '0;
            r_prod  <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand <= {{DATA_W{1'b0}}, r_acc};
            r_mpl   <= bus.instr_operand;
            r_prod  <= '0;
        end else if (bus.ena && r_state == MUL) begin
            r_mcand <= r_mcand << 1;
            r_mpl   <= r_mpl >> 1;
            r_prod  <= w_prod_nxt;
        end
`endif

    // Datapath: single-cycle writes on accept, one shift/multiply step per enabled busy cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_acc          <= '0;
            r_flags        <= '0;
            r_cnt          <= '0;
            r_left         <= 1'b0;
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_illegal      <= 1'b0;
            if (w_accept) begin
                r_result_valid <= !w_is_shift && !w_is_mul;
                r_illegal      <= w_illegal_op;
                r_cnt          <= w_is_mul ? CNT_W'(DATA_W) : CNT_W'(w_amt);
                r_left         <= bus.instr_opcode == OP_SHL;
                if (!w_is_shift && !w_is_mul) begin
                    r_acc   <= w_alu_res;
                    r_flags <= w_alu_flags;
                end
                if (bus.instr_opcode == OP_STR) r_regs[w_idx] <= r_acc;
            end else if (bus.ena && r_state == SHIFT) begin
                r_acc          <= w_sh_res;
                r_flags        <= mk_flags(r_flags[FLAG_V], w_sh_c, w_sh_res[DATA_W-1], w_sh_res == '0);
                r_cnt          <= r_cnt - 1'b1;
                r_result_valid <= w_last;
`ifdef CPU_MUL_EN
            end else if (bus.ena && r_state == MUL) begin
                r_cnt <= r_cnt - 1'b1;
                if (w_last) begin
                    r_acc          <= w_prod_nxt[DATA_W-1:0];
                    r_flags        <= mk_flags(1'b0, |w_prod_nxt[2*DATA_W-1:DATA_W],
                                               w_prod_nxt[DATA_W-1], w_prod_nxt[DATA_W-1:0] == '0);
                    r_result_valid <= 1'b1;
                end
`endif
            end
        end

    assign bus.instr_ready  = w_ready;
    assign bus.busy         = w_busy;
    assign bus.acc_out      = r_acc;
    assign bus.flags_out    = r_flags;
    assign bus.result_valid = r_result_valid;
    assign bus.illegal      = r_illegal;
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: directed scoreboard bench for acc_cpu_core (DATA_W=8, NREGS=4; MUL tests under CPU_MUL_EN)
module tb_acc_cpu_core;
    typedef struct {
        logic [7:0] acc;
        logic [3:0] fl;
        logic       ill;
        int         due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t sb [$];

    acc_cpu_if #(.DATA_W(8)) bus ();

    acc_cpu_core #(.DATA_W(8), .NREGS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Result monitor: every result_valid pulse must match the oldest expectation, on time
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            check("result_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("acc", bus.acc_out, e.acc);
                check("flags", bus.flags_out, e.fl);
                check("illegal", bus.illegal, e.ill);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] opd, input logic [7:0] eacc,
                         input logic [3:0] efl, input logic eill, input int lat, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.instr_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", bus.instr_ready, 1);
        bus.instr_valid   = 1'b1;
        bus.instr_opcode  = op;
        bus.instr_operand = opd;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        if (push) sb.push_back('{eacc, efl, eill, cyc + lat});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_opcode = 4'h0;
        bus.instr_operand = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_acc", bus.acc_out, 8'h00);
        check("reset_flags", bus.flags_out, 4'h0);
        check("reset_ready", bus.instr_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_rv", bus.result_valid, 0);
        check("reset_illegal", bus.illegal, 0);
        // flags are {V,C,N,Z}
        issue(4'h1, 8'hF0, 8'hF0, 4'b0010, 0, 0, 1);
        issue(4'h2, 8'h20, 8'h10, 4'b0100, 0, 0, 1);
        issue(4'h1, 8'h7F, 8'h7F, 4'b0100, 0, 0, 1);
        issue(4'h2, 8'h01, 8'h80, 4'b1010, 0, 0, 1);
        issue(4'h1, 8'h05, 8'h05, 4'b1000, 0, 0, 1);
        issue(4'h3, 8'h05, 8'h00, 4'b0001, 0, 0, 1);
        issue(4'h1, 8'h3C, 8'h3C, 4'b0000, 0, 0, 1);
        issue(4'h7, 8'h02, 8'h3C, 4'b0000, 0, 0, 1);
        issue(4'hD, 8'h00, 8'h00, 4'b0001, 0, 0, 1);
        issue(4'h9, 8'h02, 8'h3C, 4'b0000, 0, 0, 1);
        issue(4'hD, 8'h00, 8'h00, 4'b0001, 0, 0, 1);
        issue(4'h8, 8'h02, 8'h3C, 4'b0000, 0, 0, 1);
        issue(4'h1, 8'h21, 8'h21, 4'b0000, 0, 0, 1);
        issue(4'hA, 8'h03, 8'h08, 4'b0100, 0, 3, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("shl_ready_low", bus.instr_ready, 0);
            check("shl_busy", bus.busy, 1);
        end
        @(negedge clk);
        check("shl_ready_back", bus.instr_ready, 1);
        check("shl_busy_done", bus.busy, 0);
        issue(4'h1, 8'h21, 8'h21, 4'b0100, 0, 0, 1);
        issue(4'hB, 8'h00, 8'h21, 4'b0100, 0, 0, 1);
        issue(4'hB, 8'h02, 8'h08, 4'b0000, 0, 4, 1);
        bus.ena = 1'b0;
        @(negedge clk);
        check("freeze_busy", bus.busy, 1);
        check("freeze_ready", bus.instr_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("freeze_acc", bus.acc_out, 8'h21);
        @(posedge clk);
        #1 bus.ena = 1'b1;
        issue(4'h0, 8'h00, 8'h08, 4'b0000, 0, 0, 1);
        issue(4'hF, 8'h55, 8'h08, 4'b0000, 1, 0, 1);
        issue(4'hE, 8'hF8, 8'h00, 4'b0101, 0, 0, 1);
        issue(4'hE, 8'h01, 8'h02, 4'b0000, 0, 0, 1);
`ifdef CPU_MUL_EN
        issue(4'h1, 8'h12, 8'h12, 4'b0000, 0, 0, 1);
        issue(4'hC, 8'h0E, 8'hFC, 4'b0010, 0, 8, 1);
        issue(4'h1, 8'h20, 8'h20, 4'b0000, 0, 0, 1);
        issue(4'hC, 8'h10, 8'h00, 4'b0101, 0, 8, 1);
        issue(4'h1, 8'h12, 8'h12, 4'b0100, 0, 0, 1);
        issue(4'hC, 8'h0E, 8'h00, 4'b0000, 0, 8, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check("async_reset_acc", bus.acc_out, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("mul_abort_acc", bus.acc_out, 8'h00);
        check("mul_abort_flags", bus.flags_out, 4'h0);
        check("mul_abort_busy", bus.busy, 0);
        check("mul_abort_ready", bus.instr_ready, 1);
        repeat (12) @(negedge clk);
`else
        issue(4'hC, 8'h0E, 8'h02, 4'b0000, 1, 0, 1);
`endif
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
